// File: rtl/led_blink_scheduler.sv
// Multi-channel LED sequencer: one shared prescaler tick drives NCH channels,
// each configurable as OFF, ON, free-running BLINK or a counted BURST.
//
// state    | meaning
// CH_OFF   | LED held low, ticks ignored
// CH_ON    | LED held high, ticks ignored
// CH_BLINK | LED toggles every eff_period ticks, forever
// CH_BURST | like BLINK; each high->low toggle consumes one pulse, then OFF

module led_blink_scheduler #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 10,
  parameter int NCH     = 4,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [3:0]     cfg_period,
  input  logic [3:0]     cfg_count,
  output logic [NCH-1:0] LED,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done_pulse,
  output logic           tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("led_blink_scheduler: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NCH < 1 || NCH > 16) begin : g_bad_nch
      $error("led_blink_scheduler: NCH must be in 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    CH_OFF   = 2'b00,
    CH_ON    = 2'b01,
    CH_BLINK = 2'b10,
    CH_BURST = 2'b11
  } ch_mode_t;

  logic [PW-1:0]  presc;
  logic           tick_now;
  logic [NCH-1:0] wr_hit;

  ch_mode_t       ch_state  [NCH];
  logic [3:0]     phase     [NCH];
  logic [3:0]     period    [NCH];
  logic [3:0]     remaining [NCH];

  function automatic logic [3:0] eff_per(input logic [3:0] p);
    return (p == 4'd0) ? 4'd1 : p;
  endfunction

  // Channels act on the same edge that raises the registered tick strobe.
  assign tick_now = (presc == DIV_LAST);

  always_comb begin
    wr_hit = '0;
    if (cfg_valid && cfg_ready) begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(cfg_ch) == i) wr_hit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      presc     <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      if (tick_now) begin
        presc <= '0;
        tick  <= 1'b1;
      end else begin
        presc <= presc + 1'b1;
        tick  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        ch_state[i]  <= CH_OFF;
        phase[i]     <= 4'd0;
        period[i]    <= 4'd0;
        remaining[i] <= 4'd0;
      end
      LED        <= '0;
      busy       <= '0;
      done_pulse <= '0;
    end else begin
      done_pulse <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (wr_hit[i]) begin
          // A write always wins over a coincident tick and aborts any burst.
          busy[i] <= 1'b0;
          case (ch_mode_t'(cfg_mode))
            CH_OFF: begin
              ch_state[i] <= CH_OFF;
              LED[i]      <= 1'b0;
            end
            CH_ON: begin
              ch_state[i] <= CH_ON;
              LED[i]      <= 1'b1;
            end
            CH_BLINK: begin
              ch_state[i] <= CH_BLINK;
              LED[i]      <= 1'b1;
              phase[i]    <= 4'd0;
              period[i]   <= cfg_period;
            end
            default: begin
              if (cfg_count != 4'd0) begin
                ch_state[i]  <= CH_BURST;
                LED[i]       <= 1'b1;
                phase[i]     <= 4'd0;
                period[i]    <= cfg_period;
                remaining[i] <= cfg_count;
                busy[i]      <= 1'b1;
              end else begin
                ch_state[i]   <= CH_OFF;
                LED[i]        <= 1'b0;
                done_pulse[i] <= 1'b1;
              end
            end
          endcase
        end else if (tick_now && (ch_state[i] == CH_BLINK || ch_state[i] == CH_BURST)) begin
          if (phase[i] == eff_per(period[i]) - 4'd1) begin
            phase[i] <= 4'd0;
            LED[i]   <= ~LED[i];
            if (ch_state[i] == CH_BURST && LED[i]) begin
              if (remaining[i] == 4'd1) begin
                ch_state[i]   <= CH_OFF;
                busy[i]       <= 1'b0;
                done_pulse[i] <= 1'b1;
                remaining[i]  <= 4'd0;
              end else begin
                remaining[i] <= remaining[i] - 4'd1;
              end
            end
          end else begin
            phase[i] <= phase[i] + 4'd1;
          end
        end
      end
    end
  end

endmodule
